// File: rtl/codec_cfg_seq.sv
// codec_cfg_seq: WM8731 setup sequencer, 11 three-byte I2C writes with per-word NACK retry.
// Optional CODEC_BUS_CLEAR_EN: each run first sends 9 released-SDA SCL pulses plus a STOP.
module codec_cfg_seq #(
    parameter int         CLK_DIV   = 125,
    parameter logic [7:0] DEV_ADDR  = 8'h34,
    parameter int         RETRY_MAX = 3,
    parameter int         GAP_Q     = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    output logic       i2c_sclk,
    output logic       i2c_sdat_oe,
    input  logic       i2c_sdat_in,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] cur_index
);
    localparam int DW = $clog2(CLK_DIV + 1);
    typedef enum logic [3:0] {S_IDLE, S_CLR, S_START, S_BYTE, S_ACK, S_STOP, S_GAP, S_FIN, S_ERR} state_t;
    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    qtr_q, qtr_d, byte_q, byte_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [3:0]    idx_q, idx_d, retry_q, retry_d;
    logic          nack_q, nack_d, clr_q, clr_d, scl_q, scl_d, oe_q, oe_d, tick;
    logic [15:0]   entry;
    logic [7:0]    cur_byte;
    assign busy        = !(state_q inside {S_IDLE, S_FIN, S_ERR});
    assign done        = state_q == S_FIN || state_q == S_ERR;
    assign error       = state_q == S_ERR;
    assign cur_index   = idx_q;
    assign i2c_sclk    = scl_q;
    assign i2c_sdat_oe = oe_q;
    assign tick        = div_q == DW'(CLK_DIV - 1);
    // {reg[6:0], data[8:0]}; byte 1 on the wire is entry[15:8]
    always_comb begin
        case (idx_d)
            4'd0:    entry = {7'd15, 9'h000};
            4'd1:    entry = {7'd6,  9'h000};
            4'd2:    entry = {7'd0,  9'h017};
            4'd3:    entry = {7'd1,  9'h017};
            4'd4:    entry = {7'd2,  9'h079};
            4'd5:    entry = {7'd3,  9'h079};
            4'd6:    entry = {7'd4,  9'h012};
            4'd7:    entry = {7'd5,  9'h000};
            4'd8:    entry = {7'd7,  9'h042};
            4'd9:    entry = {7'd8,  9'h000};
            4'd10:   entry = {7'd9,  9'h001};
            default: entry = '0;
        endcase
    end
    assign cur_byte = byte_d == 2'd0 ? DEV_ADDR : byte_d == 2'd1 ? entry[15:8] : entry[7:0];
    always_comb begin
        state_d = state_q;
        div_d   = busy && !tick ? div_q + 1'b1 : '0;
        qtr_d   = qtr_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        idx_d   = idx_q;
        retry_d = retry_q;
        nack_d  = nack_q;
        clr_d   = clr_q;
        if (!busy) begin
            if (start) begin
`ifdef CODEC_BUS_CLEAR_EN
                state_d = S_CLR;
                clr_d   = 1'b1;
`else
                state_d = S_START;
                clr_d   = 1'b0;
`endif
                qtr_d   = '0;
                cnt_d   = '0;
                byte_d  = '0;
                idx_d   = '0;
                retry_d = '0;
                nack_d  = 1'b0;
            end
        end else if (tick) begin
            qtr_d = qtr_q + 1'b1;
            case (state_q)
                S_CLR: if (qtr_q == 2'd3) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == 8'd8) begin
                        state_d = S_STOP;
                        cnt_d   = '0;
                    end
                end
                S_START: if (qtr_q == 2'd1) begin
                    state_d = S_BYTE;
                    qtr_d   = '0;
                    cnt_d   = '0;
                    byte_d  = '0;
                    nack_d  = 1'b0;
                end
                S_BYTE: if (qtr_q == 2'd3) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == 8'd7) begin
                        state_d = S_ACK;
                        cnt_d   = '0;
                    end
                end
                S_ACK: begin
                    if (qtr_q == 2'd2) nack_d = i2c_sdat_in;
                    if (qtr_q == 2'd3) begin
                        state_d = nack_q || byte_q == 2'd2 ? S_STOP : S_BYTE;
                        byte_d  = byte_q + 1'b1;
                    end
                end
                S_STOP: if (qtr_q == 2'd2) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end
                S_GAP: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == 8'(GAP_Q - 1)) begin
                        state_d = S_START;
                        qtr_d   = '0;
                        // a finished bus clear goes straight on to index 0
                        if (clr_q) clr_d = 1'b0;
                        else if (nack_q) begin
                            if (retry_q == 4'(RETRY_MAX)) state_d = S_ERR;
                            else retry_d = retry_q + 1'b1;
                        end else begin
                            retry_d = '0;
                            if (idx_q == 4'd10) state_d = S_FIN;
                            else idx_d = idx_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
    // pins are registered from the next phase so they change in step with the state
    always_comb begin
        scl_d = 1'b1;
        oe_d  = 1'b0;
        case (state_d)
            S_CLR, S_ACK: scl_d = qtr_d == 2'd1 || qtr_d == 2'd2;
            S_START:      oe_d  = qtr_d == 2'd1;
            S_BYTE: begin
                scl_d = qtr_d == 2'd1 || qtr_d == 2'd2;
                oe_d  = !cur_byte[~cnt_d[2:0]];
            end
            S_STOP: begin
                scl_d = qtr_d != 2'd0;
                oe_d  = qtr_d != 2'd2;
            end
            default: ;
        endcase
    end
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            qtr_q   <= '0;
            cnt_q   <= '0;
            byte_q  <= '0;
            idx_q   <= '0;
            retry_q <= '0;
            nack_q  <= 1'b0;
            clr_q   <= 1'b0;
            scl_q   <= 1'b1;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            qtr_q   <= qtr_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            idx_q   <= idx_d;
            retry_q <= retry_d;
            nack_q  <= nack_d;
            clr_q   <= clr_d;
            scl_q   <= scl_d;
            oe_q    <= oe_d;
        end
    end
endmodule
